present80_key_schedule: RTL

- Iterative PRESENT-80 key schedule that produces the 64-bit round keys K1..K32 one at a time.
- Sits directly upstream of the round datapath. Its round_key output is XORed into the state (addRoundKey) before the S-Box layer and P-Layer.
- Holds an 80-bit key register and a round index, and advances on a next/valid handshake driven by the encryption core controller.
- Contains its own S-Box nibble lookup, identical to the PRESENT S-Box: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.

---
 rtl/present80_key_schedule_if.sv | 33 +++
 rtl/present80_key_schedule.sv | 102 ++++++++++
 2 files changed

// File: rtl/present80_key_schedule_if.sv
// rtl/present80_key_schedule_if.sv - controller/key-schedule handshake bundle (prev exists only with KS_INVERSE_EN)
interface present80_key_schedule_if;
  logic        key_load;
  logic [79:0] key_in;
  logic        next;
`ifdef KS_INVERSE_EN
  logic        prev;
`endif
  logic [63:0] round_key;
  logic [5:0]  round_idx;
  logic        key_valid;
  logic        last_round;

`ifdef KS_INVERSE_EN
  modport master (
    output key_load, key_in, next, prev,
    input  round_key, round_idx, key_valid, last_round
  );
  modport slave (
    input  key_load, key_in, next, prev,
    output round_key, round_idx, key_valid, last_round
  );
`else
  modport master (
    output key_load, key_in, next,
    input  round_key, round_idx, key_valid, last_round
  );
  modport slave (
    input  key_load, key_in, next,
    output round_key, round_idx, key_valid, last_round
  );
`endif
endinterface

// File: rtl/present80_key_schedule.sv
// rtl/present80_key_schedule.sv - iterative PRESENT-80 round key generator; KS_INVERSE_EN adds backward stepping
module present80_key_schedule #(
  parameter int KEY_W    = 80,
  parameter int NUM_KEYS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  present80_key_schedule_if.slave  ks
);

  localparam logic [5:0] IDX_LAST = 6'(NUM_KEYS);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  logic [KEY_W-1:0] r_key;
  logic [5:0]       r_idx;
  logic             r_valid;
  logic             r_last;

  logic [79:0]      w_fwd;
  logic [5:0]       w_idx_up;
  logic             w_do_next;

  // Forward step: rotate left 61, S-Box the top nibble, fold in the index being left
  always_comb begin
    w_fwd          = {r_key[18:0], r_key[79:19]};
    w_fwd[79:76]   = sbox(w_fwd[79:76]);
    w_fwd[19:15]   = w_fwd[19:15] ^ r_idx[4:0];
  end

  assign w_idx_up = r_idx + 6'd1;

`ifdef KS_INVERSE_EN
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  logic [79:0] w_u;
  logic [79:0] w_inv;
  logic [5:0]  w_idx_dn;
  logic        w_do_prev;

  // Inverse step: undo the index fold and S-Box, then rotate right 61
  always_comb begin
    w_idx_dn     = r_idx - 6'd1;
    w_u          = r_key;
    w_u[19:15]   = w_u[19:15] ^ w_idx_dn[4:0];
    w_u[79:76]   = sbox_inv(w_u[79:76]);
    w_inv        = {w_u[60:0], w_u[79:61]};
  end

  // next and prev together cancel out
  assign w_do_next = ks.next && !ks.prev && r_valid && (r_idx < IDX_LAST);
  assign w_do_prev = ks.prev && !ks.next && r_valid && (r_idx > 6'd1);
`else
  assign w_do_next = ks.next && r_valid && (r_idx < IDX_LAST);
`endif

  // Key register and round index; load wins over any step request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_idx   <= 6'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (ks.key_load) begin
      r_key   <= ks.key_in;
      r_idx   <= 6'd1;
      r_valid <= 1'b1;
      r_last  <= 1'b0;
    end else if (w_do_next) begin
      r_key   <= w_fwd;
      r_idx   <= w_idx_up;
      r_last  <= (w_idx_up == IDX_LAST);
    end
`ifdef KS_INVERSE_EN
    else if (w_do_prev) begin
      r_key   <= w_inv;
      r_idx   <= w_idx_dn;
      r_last  <= 1'b0;
    end
`endif
  end

  assign ks.round_key  = r_key[79:16];
  assign ks.round_idx  = r_idx;
  assign ks.key_valid  = r_valid;
  assign ks.last_round = r_last;

endmodule
